// File: rtl/step_ctrl.sv
// Step sequencer for the cellular-automaton engine.
// Turns synchronized slow_clk edges or single-step pulses into step_req/step_ack handshakes.
module step_ctrl #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             run,
    input  logic             single,
    output logic             step_req,
    input  logic             step_ack,
    output logic [CNT_W-1:0] gen_count,
    output logic             missed,
    input  logic             clr_missed
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   arm_q;
    logic                   prev_q;
    logic                   tick_q;
    logic                   single_q;
    logic                   single_ev_q;
    logic                   pending_q, pending_d;
    logic                   set_miss;
    logic                   inc;
    logic                   step_ev;

    // arm_q masks ticks until the sync chain holds post-reset samples
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            arm_q       <= '0;
            prev_q      <= 1'b0;
            tick_q      <= 1'b0;
            single_q    <= 1'b0;
            single_ev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            arm_q       <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            prev_q      <= sync_q[SYNC_STAGES-1];
            tick_q      <= sync_q[SYNC_STAGES-1] & ~prev_q & arm_q[SYNC_STAGES];
            single_q    <= single;
            single_ev_q <= single & ~single_q;
        end
    end

    assign step_ev = (tick_q & run) | single_ev_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        set_miss  = 1'b0;
        inc       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (step_ev | pending_q) begin
                    state_d   = REQ;
                    pending_d = step_ev & pending_q;
                end
            end
            REQ: begin
                if (step_ack) begin
                    state_d = IDLE;
                    inc     = 1'b1;
                end
                if (step_ev) begin
                    if (pending_q) set_miss = 1'b1;
                    else           pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            gen_count <= '0;
            missed    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (inc) gen_count <= gen_count + CNT_W'(1);
            missed    <= set_miss | (missed & ~clr_missed);
        end
    end

    assign step_req = (state_q == REQ);

endmodule

// File: tb/tb_step_ctrl.sv
// Randomized scoreboard bench for step_ctrl.
// Reference model tracks outstanding steps as a token count (capacity two).
module tb_step_ctrl;

    localparam int CNT_W = 4;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             slow_clk;
    logic             run;
    logic             single;
    logic             step_req;
    logic             step_ack;
    logic [CNT_W-1:0] gen_count;
    logic             missed;
    logic             clr_missed;

    always #5 clk = ~clk;

    step_ctrl #(
        .CNT_W(CNT_W),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_in(clk),
        .rst_n(rst_n),
        .slow_clk(slow_clk),
        .run(run),
        .single(single),
        .step_req(step_req),
        .step_ack(step_ack),
        .gen_count(gen_count),
        .missed(missed),
        .clr_missed(clr_missed)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic             req;
        logic [CNT_W-1:0] gen;
        logic             miss;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    int  tick_due[$];
    int  edge_n;
    bit  hist_v;
    bit  hist_last;
    bit  sgl_prev;
    bit  sgl_due;
    int  outst;
    bit  req_m;
    int  gen_m;
    bit  miss_m;

    always @(posedge clk or negedge rst_n) begin
        bit ev, acc, set_m;
        exp_t e;
        if (!rst_n) begin
            tick_due.delete();
            exp_q.delete();
            edge_n    = 0;
            hist_v    = 0;
            hist_last = 0;
            sgl_prev  = 0;
            sgl_due   = 0;
            outst     = 0;
            req_m     = 0;
            gen_m     = 0;
            miss_m    = 0;
        end else begin
            edge_n++;
            ev = sgl_due;
            if (tick_due.size() > 0 && tick_due[0] == edge_n) begin
                void'(tick_due.pop_front());
                if (run) ev = 1;
            end
            sgl_due  = single && !sgl_prev;
            sgl_prev = single;
            // a rise counts only if a low level was seen after reset
            if (hist_v && !hist_last && slow_clk)
                tick_due.push_back(edge_n + SS + 1);
            hist_v    = 1;
            hist_last = slow_clk;
            acc   = step_ack && req_m;
            set_m = 0;
            if (ev) begin
                if (outst < 2) outst++;
                else           set_m = 1;
            end
            if (acc) begin
                outst--;
                gen_m = (gen_m + 1) % (1 << CNT_W);
            end
            miss_m = set_m ? 1'b1 : (clr_missed ? 1'b0 : miss_m);
            req_m  = (outst > 0) && !acc;
            e.req  = req_m;
            e.gen  = gen_m[CNT_W-1:0];
            e.miss = miss_m;
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_step_req", step_req, 0);
            chk("rst_gen_count", gen_count, 0);
            chk("rst_missed", missed, 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("step_req", step_req, e.req);
            chk("gen_count", gen_count, e.gen);
            chk("missed", missed, e.miss);
        end
    end

    int half_cnt = 4;
    int ack_div  = 2;

    task automatic rand_cycle();
        @(posedge clk);
        #1;
        if (half_cnt == 0) begin
            slow_clk = ~slow_clk;
            half_cnt = $urandom_range(2, 9);
        end else begin
            half_cnt--;
        end
        if ($urandom_range(0, 49) == 0) run = ~run;
        single     = ($urandom_range(0, 11) == 0);
        step_ack   = ($urandom_range(0, ack_div) == 0);
        clr_missed = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        bit got;
        rst_n      = 1'b0;
        slow_clk   = 1'b1;
        run        = 1'b1;
        single     = 1'b0;
        step_ack   = 1'b0;
        clr_missed = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // slow_clk already high at release must not produce a step
        repeat (20) begin
            @(posedge clk);
            #1 step_ack = 1'($urandom_range(0, 1));
        end
        chk("slow_high_no_req", step_req, 0);
        chk("slow_high_gen", gen_count, 0);

        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) ack_div = (ack_div == 2) ? 25 : 2;
            rand_cycle();
        end

        // reset while a request is outstanding
        got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            rand_cycle();
            if (step_req) begin
                got      = 1;
                step_ack = 1'b0;
            end
        end
        chk("req_seen_before_reset", got, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_drop_req", step_req, 0);
        chk("async_gen_clear", gen_count, 0);
        chk("async_missed_clear", missed, 0);
        run    = 1'b0;
        single = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i % 3 == 0) slow_clk = ~slow_clk;
            step_ack = 1'($urandom_range(0, 1));
        end
        chk("post_reset_no_req", step_req, 0);
        chk("post_reset_gen", gen_count, 0);

        run     = 1'b1;
        ack_div = 3;
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) ack_div = (ack_div == 3) ? 30 : 3;
            rand_cycle();
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the generation counter.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, minimum 2, giving the number of synchronizer flops on slow_clk.
REQ-003 Port clk_in  input  1  is the single system clock; all flops SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous assert, active-low.
REQ-005 Port slow_clk  input  1  is the divided clock from the upstream divider, treated as asynchronous data.
REQ-006 Port run  input  1  is the free-run enable level, synchronous to clk_in.
REQ-007 Port single  input  1  is the single-step request, synchronous to clk_in; only its rising edge is significant.
REQ-008 Port step_req  output  1  is the step request to the downstream cellular-automaton engine.
REQ-009 Port step_ack  input  1  is the engine's acknowledge, synchronous to clk_in.
REQ-010 Port gen_count  output  CNT_W  is the number of completed steps, modulo 2^CNT_W.
REQ-011 Port missed  output  1  is a sticky flag indicating that a step event was lost.
REQ-012 Port clr_missed  input  1  is a synchronous clear for missed.

Function
REQ-013 slow_clk SHALL pass through a SYNC_STAGES-deep flop chain before any use.
REQ-014 A tick (one clk_in cycle) SHALL be generated on each 0->1 transition of the synchronized slow_clk.
REQ-015 No tick SHALL be generated within the first SYNC_STAGES+1 cycles after reset release, whatever the level of slow_clk.
REQ-016 A step event SHALL be (tick AND run) OR (rising edge of single, detected against the previous-cycle value of single).
REQ-017 The FSM SHALL have exactly two states, IDLE and REQ; step_req SHALL be a registered output equal to 1 exactly when the state is REQ.
REQ-018 IDLE -> REQ SHALL occur on the clock edge at which a step event is present or pending=1; pending SHALL clear on that same edge.
REQ-019 In REQ, step_req SHALL hold 1 until step_ack=1 is sampled; on that edge the state SHALL return to IDLE and gen_count SHALL increment by 1.
REQ-020 gen_count SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-021 A step event in REQ SHALL set pending when pending=0; if pending=1 already, it SHALL set missed instead.
REQ-022 A step event arriving on the same edge as the accepted step_ack SHALL set pending; the resulting request SHALL be issued from IDLE on the next edge.
REQ-023 step_req SHALL therefore be low for at least one cycle between consecutive requests.
REQ-024 Deasserting run SHALL suppress new ticks only; an existing pending flag and an outstanding REQ SHALL be retained.
REQ-025 step_ack while in IDLE SHALL be ignored and SHALL NOT change gen_count.
REQ-026 If clr_missed and a missed-setting event occur in the same cycle, the set SHALL win.
REQ-027 Latency: with run=1 and state IDLE, step_req SHALL rise on the (SYNC_STAGES+2)th rising edge of clk_in after slow_clk rises with setup met.
REQ-028 Latency: single rising at edge n with state IDLE SHALL cause step_req=1 after edge n+1.

Reset
REQ-029 While rst_n=0: state=IDLE, step_req=0, gen_count=0, missed=0, pending=0, all synchronizer and edge-detect flops=0.
REQ-030 Reset assertion mid-REQ SHALL immediately drop step_req and discard pending, with no increment of gen_count.

Verification
REQ-031 run=1, SYNC_STAGES=2, slow_clk rises, ack returned 3 cycles after step_req -> step_req rises 4 edges after slow_clk, falls 1 cycle after ack, gen_count=1.
REQ-032 slow_clk held high through reset release, run=1 -> no step_req, gen_count stays 0 until the next slow_clk rising edge.
REQ-033 run=0, single pulsed 3 times with full handshakes -> 3 requests, gen_count=3; slow_clk edges in between -> no requests.
REQ-034 step_ack held 0, three ticks arrive -> pending=1 after the 2nd tick, missed=1 after the 3rd; after ack, exactly one further request; clr_missed -> missed=0.
REQ-035 CNT_W=4, 16 completed steps -> gen_count sequence 1..15, then 0.
REQ-036 rst_n pulsed low while step_req=1 -> step_req=0 asynchronously, gen_count=0, and no request after release until a new event.
